// File: rtl/vga_pkg.sv
// Timing-set definitions shared by the VGA raster generator and its axis counters.
// A timing set holds both axes plus the active level of each sync pin.
package vga_pkg;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_fp;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [11:0] v_active;
    logic [11:0] v_fp;
    logic [11:0] v_sync;
    logic [11:0] v_bp;
    logic        h_pol;
    logic        v_pol;
  } timing_t;

  localparam timing_t VGA_800x600_72 = '{
    h_active: 12'd800, h_fp: 12'd56, h_sync: 12'd120, h_bp: 12'd64,
    v_active: 12'd600, v_fp: 12'd37, v_sync: 12'd6,   v_bp: 12'd23,
    h_pol:    1'b1,    v_pol: 1'b1
  };

  localparam timing_t VGA_640x480_60 = '{
    h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
    v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33,
    h_pol:    1'b0,    v_pol: 1'b0
  };

  function automatic logic [11:0] h_total(input timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic logic [11:0] v_total(input timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus active/sync decode of its next value.
// Wrap uses the totals of the running mode; decode uses the mode that applies next cycle.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         en,
  input  logic [W-1:0] cur_total,
  input  logic [W-1:0] nxt_active,
  input  logic [W-1:0] nxt_fp,
  input  logic [W-1:0] nxt_sync,
  input  logic         nxt_pol,
  output logic [W-1:0] count_next,
  output logic         wrap,
  output logic         active_next,
  output logic         pulse_next,
  output logic         sync_pin
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         sync_pin_q;
  logic         sync_pin_d;
  logic [W:0]   pulse_lo;
  logic [W:0]   pulse_hi;

  always_comb begin
    wrap  = (cnt_q == cur_total - W'(1));
    cnt_d = cnt_q;
    if (Reset) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end

    // One extra bit so active+fp+sync cannot overflow the compare.
    pulse_lo    = {1'b0, nxt_active} + {1'b0, nxt_fp};
    pulse_hi    = pulse_lo + {1'b0, nxt_sync};
    active_next = (cnt_d < nxt_active);
    pulse_next  = ({1'b0, cnt_d} >= pulse_lo) && ({1'b0, cnt_d} < pulse_hi);
    sync_pin_d  = pulse_next ? nxt_pol : ~nxt_pol;
  end

  always_ff @(posedge Clock) begin
    cnt_q      <= cnt_d;
    sync_pin_q <= sync_pin_d;
  end

  assign count_next = cnt_d;
  assign sync_pin   = sync_pin_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Dual-mode VGA raster timing generator; the mode switches only on a frame boundary.
// Every output is a flop loaded from decode of the next counter state.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int      COORD_W = 12,
  parameter timing_t MODE0   = VGA_800x600_72,
  parameter timing_t MODE1   = VGA_640x480_60
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               mode_sel,
  output logic               mode_active,
  output logic [COORD_W-1:0] nextX,
  output logic [COORD_W-1:0] nextY,
  output logic               blank_n,
  output logic               hSync_n,
  output logic               vSync_n,
  output logic               sync_n,
  output logic               line_start,
  output logic               frame_start
);

  localparam logic [COORD_W-1:0] HT0 = COORD_W'(h_total(MODE0));
  localparam logic [COORD_W-1:0] HT1 = COORD_W'(h_total(MODE1));
  localparam logic [COORD_W-1:0] VT0 = COORD_W'(v_total(MODE0));
  localparam logic [COORD_W-1:0] VT1 = COORD_W'(v_total(MODE1));

  logic               mode_q, mode_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               blank_q, blank_d;
  logic               sync_q, sync_d;
  logic               line_q, line_d;
  logic               frame_q, frame_d;

  logic [COORD_W-1:0] h_tot, v_tot;
  logic [COORD_W-1:0] h_cnt_n, v_cnt_n;
  logic               h_wrap, v_wrap;
  logic               h_act_n, v_act_n;
  logic               h_pulse_n, v_pulse_n;
  logic               h_pin, v_pin;
  logic               frame_end;
  logic               active_d;

  always_comb begin
    frame_end = h_wrap & v_wrap;
    // The requested mode is only taken at reset or on the last pixel of a frame.
    mode_d    = (Reset || frame_end) ? mode_sel : mode_q;
    h_tot     = mode_q ? HT1 : HT0;
    v_tot     = mode_q ? VT1 : VT0;

    active_d  = h_act_n & v_act_n;
    x_d       = active_d ? h_cnt_n : '0;
    y_d       = active_d ? v_cnt_n : '0;
    blank_d   = active_d;
    sync_d    = ~(h_pulse_n | v_pulse_n);
    line_d    = (h_cnt_n == '0);
    frame_d   = line_d && (v_cnt_n == '0);
  end

  vga_axis_counter #(.W(COORD_W)) u_h_axis (
    .Clock       (Clock),
    .Reset       (Reset),
    .en          (1'b1),
    .cur_total   (h_tot),
    .nxt_active  (mode_d ? COORD_W'(MODE1.h_active) : COORD_W'(MODE0.h_active)),
    .nxt_fp      (mode_d ? COORD_W'(MODE1.h_fp)     : COORD_W'(MODE0.h_fp)),
    .nxt_sync    (mode_d ? COORD_W'(MODE1.h_sync)   : COORD_W'(MODE0.h_sync)),
    .nxt_pol     (mode_d ? MODE1.h_pol : MODE0.h_pol),
    .count_next  (h_cnt_n),
    .wrap        (h_wrap),
    .active_next (h_act_n),
    .pulse_next  (h_pulse_n),
    .sync_pin    (h_pin)
  );

  vga_axis_counter #(.W(COORD_W)) u_v_axis (
    .Clock       (Clock),
    .Reset       (Reset),
    .en          (h_wrap),
    .cur_total   (v_tot),
    .nxt_active  (mode_d ? COORD_W'(MODE1.v_active) : COORD_W'(MODE0.v_active)),
    .nxt_fp      (mode_d ? COORD_W'(MODE1.v_fp)     : COORD_W'(MODE0.v_fp)),
    .nxt_sync    (mode_d ? COORD_W'(MODE1.v_sync)   : COORD_W'(MODE0.v_sync)),
    .nxt_pol     (mode_d ? MODE1.v_pol : MODE0.v_pol),
    .count_next  (v_cnt_n),
    .wrap        (v_wrap),
    .active_next (v_act_n),
    .pulse_next  (v_pulse_n),
    .sync_pin    (v_pin)
  );

  always_ff @(posedge Clock) begin
    mode_q  <= mode_d;
    x_q     <= x_d;
    y_q     <= y_d;
    blank_q <= blank_d;
    sync_q  <= sync_d;
    line_q  <= line_d;
    frame_q <= frame_d;
  end

  assign mode_active = mode_q;
  assign nextX       = x_q;
  assign nextY       = y_q;
  assign blank_n     = blank_q;
  assign hSync_n     = h_pin;
  assign vSync_n     = v_pin;
  assign sync_n      = sync_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a small-timing instance for frame/mode-switch sequences, a default instance for real line timing.
// A reference raster model pushes expected outputs per cycle; they are popped and compared after each edge.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam timing_t TA0 = '{
    h_active: 12'd8, h_fp: 12'd2, h_sync: 12'd3, h_bp: 12'd3,
    v_active: 12'd4, v_fp: 12'd1, v_sync: 12'd2, v_bp: 12'd1,
    h_pol: 1'b1, v_pol: 1'b1
  };
  localparam timing_t TA1 = '{
    h_active: 12'd6, h_fp: 12'd1, h_sync: 12'd2, h_bp: 12'd1,
    v_active: 12'd3, v_fp: 12'd1, v_sync: 12'd1, v_bp: 12'd2,
    h_pol: 1'b0, v_pol: 1'b0
  };

  typedef struct packed {
    logic        mode;
    logic [11:0] x;
    logic [11:0] y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        sync;
    logic        ls;
    logic        fs;
  } obs_t;

  typedef struct {
    logic rst;
    logic sel;
    int   cyc;
    logic exp_mode;
    int   exp_period;
    bit   snap;
    bit   hold;
  } seg_t;

  logic        Clock = 1'b0;
  logic        Reset_a = 1'b1, mode_sel_a = 1'b0;
  logic        Reset_b = 1'b1, mode_sel_b = 1'b0;
  logic        mode_a, blank_a, hs_a, vs_a, sync_a, ls_a, fs_a;
  logic        mode_b, blank_b, hs_b, vs_b, sync_b, ls_b, fs_b;
  logic [11:0] x_a, y_a, x_b, y_b;

  always #5 Clock = ~Clock;

  vga_timing_gen #(.COORD_W(12), .MODE0(TA0), .MODE1(TA1)) u_a (
    .Clock(Clock), .Reset(Reset_a), .mode_sel(mode_sel_a), .mode_active(mode_a),
    .nextX(x_a), .nextY(y_a), .blank_n(blank_a), .hSync_n(hs_a), .vSync_n(vs_a),
    .sync_n(sync_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen u_b (
    .Clock(Clock), .Reset(Reset_b), .mode_sel(mode_sel_b), .mode_active(mode_b),
    .nextX(x_b), .nextY(y_b), .blank_n(blank_b), .hSync_n(hs_b), .vSync_n(vs_b),
    .sync_n(sync_b), .line_start(ls_b), .frame_start(fs_b)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mh [2];
  int   mv [2];
  logic mm [2];
  obs_t q_a[$];
  obs_t q_b[$];

  int   last_fs_a = -1, per_a = -1, mc_a = 0, mc_snap = 0;
  logic prev_mode_a = 1'bx;
  int   last_ls_b = -1, lper_b = -1, hs_cnt_b = 0, hs_line_b = -1, xmax_b = 0;

  function automatic timing_t pick(input int d, input logic m);
    if (d == 0) return m ? TA1 : TA0;
    return m ? VGA_640x480_60 : VGA_800x600_72;
  endfunction

  task automatic model_step(input int d, input logic rst, input logic sel);
    timing_t t;
    int ht, vt;
    if (rst) begin
      mh[d] = 0; mv[d] = 0; mm[d] = sel;
    end else begin
      t  = pick(d, mm[d]);
      ht = int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
      vt = int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
      if (mh[d] == ht - 1) begin
        mh[d] = 0;
        if (mv[d] == vt - 1) begin
          mv[d] = 0;
          mm[d] = sel;
        end else begin
          mv[d] = mv[d] + 1;
        end
      end else begin
        mh[d] = mh[d] + 1;
      end
    end
  endtask

  function automatic obs_t expect_obs(input int d);
    obs_t o;
    timing_t t;
    int h, v, hlo, hhi, vlo, vhi;
    logic act, hp, vp;
    t   = pick(d, mm[d]);
    h   = mh[d];
    v   = mv[d];
    hlo = int'(t.h_active) + int'(t.h_fp);
    hhi = hlo + int'(t.h_sync);
    vlo = int'(t.v_active) + int'(t.v_fp);
    vhi = vlo + int'(t.v_sync);
    act = (h < int'(t.h_active)) && (v < int'(t.v_active));
    hp  = (h >= hlo) && (h < hhi);
    vp  = (v >= vlo) && (v < vhi);
    o.mode  = mm[d];
    o.x     = act ? 12'(h) : 12'd0;
    o.y     = act ? 12'(v) : 12'd0;
    o.blank = act;
    o.hs    = hp ? t.h_pol : ~t.h_pol;
    o.vs    = vp ? t.v_pol : ~t.v_pol;
    o.sync  = ~(hp | vp);
    o.ls    = (h == 0);
    o.fs    = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic obs_t actual(input int d);
    obs_t o;
    if (d == 0) begin
      o.mode = mode_a; o.x = x_a; o.y = y_a; o.blank = blank_a; o.hs = hs_a;
      o.vs = vs_a; o.sync = sync_a; o.ls = ls_a; o.fs = fs_a;
    end else begin
      o.mode = mode_b; o.x = x_b; o.y = y_b; o.blank = blank_b; o.hs = hs_b;
      o.vs = vs_b; o.sync = sync_b; o.ls = ls_b; o.fs = fs_b;
    end
    return o;
  endfunction

  task automatic cmp_obs(input string name, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc %0d: got mode=%b x=%0d y=%0d blank=%b hs=%b vs=%b sync=%b ls=%b fs=%b, expected mode=%b x=%0d y=%0d blank=%b hs=%b vs=%b sync=%b ls=%b fs=%b",
               name, cyc, a.mode, a.x, a.y, a.blank, a.hs, a.vs, a.sync, a.ls, a.fs,
               e.mode, e.x, e.y, e.blank, e.hs, e.vs, e.sync, e.ls, e.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic ra, input logic sa, input logic rb, input logic sb);
    Reset_a = ra; mode_sel_a = sa;
    Reset_b = rb; mode_sel_b = sb;
    model_step(0, ra, sa);
    q_a.push_back(expect_obs(0));
    model_step(1, rb, sb);
    q_b.push_back(expect_obs(1));
    @(posedge Clock);
    #1;
    cyc++;
    cmp_obs("raster_a", actual(0), q_a.pop_front());
    cmp_obs("raster_b", actual(1), q_b.pop_front());

    if (fs_a === 1'b1) begin
      if (last_fs_a >= 0) per_a = cyc - last_fs_a;
      last_fs_a = cyc;
    end
    if (mode_a !== prev_mode_a) mc_a++;
    prev_mode_a = mode_a;

    if (ls_b === 1'b1) begin
      if (last_ls_b >= 0) begin
        lper_b    = cyc - last_ls_b;
        hs_line_b = hs_cnt_b;
      end
      last_ls_b = cyc;
      hs_cnt_b  = 0;
    end
    if (hs_b === (mode_b ? 1'b0 : 1'b1)) hs_cnt_b++;
    if (int'(x_b) > xmax_b) xmax_b = int'(x_b);
  endtask

  seg_t segs [12];

  initial begin
    segs[0]  = '{rst: 1'b1, sel: 1'b0, cyc: 2,   exp_mode: 1'b0, exp_period: -1,  snap: 0, hold: 0};
    segs[1]  = '{rst: 1'b0, sel: 1'b0, cyc: 300, exp_mode: 1'b0, exp_period: 128, snap: 0, hold: 0};
    segs[2]  = '{rst: 1'b0, sel: 1'b1, cyc: 20,  exp_mode: 1'b0, exp_period: -1,  snap: 1, hold: 0};
    segs[3]  = '{rst: 1'b0, sel: 1'b0, cyc: 100, exp_mode: 1'b0, exp_period: -1,  snap: 0, hold: 1};
    segs[4]  = '{rst: 1'b0, sel: 1'b1, cyc: 50,  exp_mode: 1'b0, exp_period: -1,  snap: 0, hold: 0};
    segs[5]  = '{rst: 1'b0, sel: 1'b1, cyc: 42,  exp_mode: 1'b1, exp_period: -1,  snap: 0, hold: 0};
    segs[6]  = '{rst: 1'b0, sel: 1'b1, cyc: 210, exp_mode: 1'b1, exp_period: 70,  snap: 0, hold: 0};
    segs[7]  = '{rst: 1'b0, sel: 1'b0, cyc: 35,  exp_mode: 1'b1, exp_period: -1,  snap: 0, hold: 0};
    segs[8]  = '{rst: 1'b0, sel: 1'b0, cyc: 35,  exp_mode: 1'b0, exp_period: -1,  snap: 0, hold: 0};
    segs[9]  = '{rst: 1'b0, sel: 1'b0, cyc: 50,  exp_mode: 1'b0, exp_period: -1,  snap: 0, hold: 0};
    segs[10] = '{rst: 1'b1, sel: 1'b1, cyc: 1,   exp_mode: 1'b1, exp_period: -1,  snap: 0, hold: 0};
    segs[11] = '{rst: 1'b0, sel: 1'b1, cyc: 100, exp_mode: 1'b1, exp_period: -1,  snap: 0, hold: 0};

    // Small-timing instance: frames of 128 (mode 0) and 70 (mode 1) cycles.
    for (int i = 0; i < 12; i++) begin
      if (segs[i].snap) mc_snap = mc_a;
      for (int c = 0; c < segs[i].cyc; c++) step(segs[i].rst, segs[i].sel, 1'b1, 1'b0);
      check_int($sformatf("seg%0d_mode", i), int'(mode_a), int'(segs[i].exp_mode));
      if (segs[i].exp_period >= 0) check_int($sformatf("seg%0d_frame_period", i), per_a, segs[i].exp_period);
      if (segs[i].hold) check_int("glitch_mode_changes", mc_a - mc_snap, 0);
    end

    // Default instance, 800x600 mode: two full lines.
    last_ls_b = -1;
    hs_cnt_b  = 0;
    xmax_b    = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_int("b_reset_frame_start", int'(fs_b), 1);
    check_int("b_reset_hsync_idle", int'(hs_b), 0);
    for (int c = 0; c < 2100; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_int("b_m0_line_period", lper_b, 1040);
    check_int("b_m0_hsync_width", hs_line_b, 120);
    check_int("b_m0_max_x", xmax_b, 799);

    // Reset in the middle of a line, loading mode 1.
    for (int c = 0; c < 480; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_int("b_pre_reset_x", int'(x_b), 500);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check_int("b_rst_mid_x", int'(x_b), 0);
    check_int("b_rst_mid_y", int'(y_b), 0);
    check_int("b_rst_mid_fs", int'(fs_b), 1);
    check_int("b_rst_mid_mode", int'(mode_b), 1);
    for (int c = 0; c < 820; c++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check_int("b_m1_line_period", lper_b, 800);
    check_int("b_m1_hsync_width", hs_line_b, 96);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
